data_sram_bridge: RTL and testbench

Converts the CPU core's single-cycle data SRAM port (en / wen / addr / wdata / rdata) into a split address/data handshake towards a variable-latency data memory. It sits directly downstream of the top-level address-translation stage, on the translated data_sram_* signals. It stalls the core for the duration of each access and includes a watchdog that terminates hung transactions.

---
 rtl/data_sram_bridge.sv | 108 ++++++++++
 tb/tb_data_sram_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle data SRAM port onto a split addr/data handshake
// towards variable-latency memory, stalling the core and aborting hung accesses.
module data_sram_bridge #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            abort;

    // wd_cnt holds the cycles already spent, so the hit lands on the TIMEOUT-th cycle
    assign wd_hit = (wd_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: if (data_sram_en) state_nxt = REQ;
            REQ: begin
                if (mem_addr_ok) begin
                    state_nxt = RESP;
                end else if (wd_hit) begin
                    state_nxt = DONE;
                    abort     = 1'b1;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    state_nxt = DONE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = (state == IDLE && data_sram_en) || state == REQ || state == RESP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // mem_* double as the latched request; they hold their value after REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sram_rdata <= 32'h0;
            bus_err         <= 1'b0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_wstrb       <= 4'h0;
            mem_addr        <= 32'h0;
            mem_wdata       <= 32'h0;
            wd_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= |data_sram_wen;
                        mem_wstrb <= data_sram_wen;
                        mem_addr  <= data_sram_addr;
                        mem_wdata <= data_sram_wdata;
                        wd_cnt    <= '0;
                    end
                end
                REQ: begin
                    wd_cnt <= wd_cnt + TO_W'(1);
                    if (mem_addr_ok || abort) mem_req <= 1'b0;
                end
                RESP: begin
                    wd_cnt <= wd_cnt + TO_W'(1);
                    if (mem_data_ok && !mem_wr) data_sram_rdata <= mem_rdata;
                end
                default: ;
            endcase
            if (abort) begin
                bus_err <= 1'b1;
                if (!mem_wr) data_sram_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge with TIMEOUT=16.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stall;
    logic        bus_err;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    data_sram_bridge #(.TIMEOUT(16), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .stall(stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access starting at the next edge (IDLE cycle 0). addr_ok is pulsed in
    // cycle a_at, data_ok in cycle d_at (999 = never). Returns positioned in DONE.
    task automatic run(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd,
                       input int a_at, input int d_at, input int exp_stall,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic chain);
        int c;
        bit done;
        step();
        data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk({tag, " c0 stall"}, 32'(stall), 32'd1);
        chk({tag, " c0 mem_req"}, 32'(mem_req), 32'd0);
        c = 0;
        done = 1'b0;
        while (!done && c < 100) begin
            step();
            c++;
            mem_addr_ok = (c == a_at);
            mem_data_ok = (c == d_at);
            mem_rdata   = (c == d_at) ? rd : 32'hDEAD_BEEF;
            #1;
            if (!stall) begin
                done = 1'b1;
            end else if (c <= a_at) begin
                chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, " mem_addr"}, mem_addr, addr);
                chk({tag, " mem_wr"}, 32'(mem_wr), 32'(|wen));
                chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(wen));
                if (|wen) chk({tag, " mem_wdata"}, mem_wdata, wdata);
            end else begin
                chk({tag, " mem_req low"}, 32'(mem_req), 32'd0);
            end
        end
        if (!done) chk({tag, " cycle budget"}, 32'd1, 32'd0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        chk({tag, " stall cycles"}, 32'(c), 32'(exp_stall));
        chk({tag, " done mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " rdata"}, data_sram_rdata, exp_rdata);
        chk({tag, " bus_err"}, 32'(bus_err), 32'(exp_err));
        if (!chain) data_sram_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        #2;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst rdata", data_sram_rdata, 32'h0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
        data_sram_en = 1'b1;
        #1;
        chk("rst stall follows en", 32'(stall), 32'd1);
        data_sram_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // zero-wait read
        run("rd0", 4'h0, 32'h0000_1000, 32'h0, 32'h1234_5678, 1, 2, 3, 32'h1234_5678, 1'b0, 1'b0);
        // write with waits: rdata must be unchanged
        run("wr", 4'b0011, 32'h0000_2004, 32'hAABB_CCDD, 32'h5A5A_5A5A, 5, 8, 9, 32'h1234_5678, 1'b0, 1'b0);
        // data_ok lands on the 16th counted cycle: handshake wins
        run("sim", 4'h0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 16, 17, 32'hCAFE_F00D, 1'b0, 1'b0);
        // back-to-back read then write with en held high
        run("b2b_rd", 4'h0, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 2, 4, 5, 32'h0BAD_F00D, 1'b0, 1'b1);
        run("b2b_wr", 4'b1111, 32'h0000_4004, 32'h1357_9BDF, 32'h0, 1, 2, 3, 32'h0BAD_F00D, 1'b0, 1'b0);
        // watchdog: addr_ok never comes
        run("wdog", 4'h0, 32'h0000_5000, 32'h0, 32'h0, 999, 999, 17, 32'h0, 1'b1, 1'b0);
        step();
        chk("wdog idle stall", 32'(stall), 32'd0);
        repeat (4) step();
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("stray data_ok rdata", data_sram_rdata, 32'h0);
        chk("stray data_ok stall", 32'(stall), 32'd0);
        chk("bus_err sticky", 32'(bus_err), 32'd1);

        // reset in RESP
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_6000;
        step();
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        #1;
        chk("pre-rst RESP stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst mem_req", 32'(mem_req), 32'd0);
        chk("mid rst stall", 32'(stall), 32'd1);
        chk("mid rst bus_err", 32'(bus_err), 32'd0);
        chk("mid rst rdata", data_sram_rdata, 32'h0);
        data_sram_en = 1'b0;
        #1;
        chk("mid rst stall en0", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("post rst stray rdata", data_sram_rdata, 32'h0);
        chk("post rst stall", 32'(stall), 32'd0);
        // addr_ok while idle has no effect
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        #1;
        chk("idle addr_ok mem_req", 32'(mem_req), 32'd0);
        // normal read still works after reset
        run("rd_after", 4'h0, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 1, 3, 4, 32'h89AB_CDEF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
